// File: rtl/count_seq_checker_if.sv
// Bundles the monitored count stream and the checker's status outputs.
// The master side drives EN/Q; the checker attaches through the slave modport.
interface count_seq_checker_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             EN;
   logic [WIDTH-1:0] Q;
   logic             LOCKED;
   logic             ERR;
   logic             ERR_STICKY;
   logic             WRAP;
   logic [CNT_W-1:0] WRAP_CNT;
   logic [CNT_W-1:0] ERR_CNT;
   logic [WIDTH-1:0] EXPECTED;

   modport master (
      output EN, Q,
      input  LOCKED, ERR, ERR_STICKY, WRAP, WRAP_CNT, ERR_CNT, EXPECTED
   );

   modport slave (
      input  EN, Q,
      output LOCKED, ERR, ERR_STICKY, WRAP, WRAP_CNT, ERR_CNT, EXPECTED
   );
endinterface

// File: rtl/count_seq_checker.sv
// Watches a free-running up-counter and checks it advances by exactly +1 modulo 2^WIDTH.
// Reports lock, mismatch and wrap pulses plus saturating wrap/error statistics.
module count_seq_checker #(
   parameter int WIDTH       = 4,
   parameter int LOCK_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   count_seq_checker_if.slave   bus
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ACQ   = 2'd1,
      S_LOCK  = 2'd2
   } state_t;

   localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_CYCLES);
   localparam logic [WIDTH-1:0] MAX_VAL     = '1;
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t           r_state;
   logic [WIDTH-1:0] r_prev;
   logic [3:0]       r_match_cnt;
   logic             r_locked;
   logic             r_err;
   logic             r_err_sticky;
   logic             r_wrap;
   logic [CNT_W-1:0] r_wrap_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [WIDTH-1:0] r_expected;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_prev_nxt;
   logic [3:0]       w_match_nxt;
   logic [3:0]       w_match_inc;
   logic             w_err_nxt;
   logic             w_err_sticky_nxt;
   logic             w_wrap_nxt;
   logic [CNT_W-1:0] w_wrap_cnt_nxt;
   logic [CNT_W-1:0] w_err_cnt_nxt;
   logic [WIDTH-1:0] w_exp;
   logic             w_match;

   // Carry out of the add is discarded, which gives the modulo wrap for free.
   assign w_exp       = r_prev + WIDTH'(1);
   assign w_match     = (bus.Q == w_exp);
   assign w_match_inc = r_match_cnt + 4'd1;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
      w_state_nxt      = r_state;
      w_prev_nxt       = r_prev;
      w_match_nxt      = r_match_cnt;
      w_err_nxt        = 1'b0;
      w_wrap_nxt       = 1'b0;
      w_err_sticky_nxt = r_err_sticky;
      w_wrap_cnt_nxt   = r_wrap_cnt;
      w_err_cnt_nxt    = r_err_cnt;

      if (bus.EN) begin
         w_prev_nxt = bus.Q;
         unique case (r_state)
            S_EMPTY: begin
               w_match_nxt = '0;
               w_state_nxt = S_ACQ;
            end
            S_ACQ: begin
               if (w_match) begin
                  w_match_nxt = w_match_inc;
                  if (w_match_inc == LOCK_TARGET) w_state_nxt = S_LOCK;
               end else begin
                  w_match_nxt = '0;
               end
            end
            S_LOCK: begin
               if (w_match) begin
                  // Only a wrap seen while already locked is reported.
                  if (r_prev == MAX_VAL && bus.Q == '0) begin
                     w_wrap_nxt = 1'b1;
                     if (r_wrap_cnt != CNT_MAX) w_wrap_cnt_nxt = r_wrap_cnt + CNT_W'(1);
                  end
               end else begin
                  w_err_nxt        = 1'b1;
                  w_err_sticky_nxt = 1'b1;
                  w_state_nxt      = S_ACQ;
                  w_match_nxt      = '0;
                  if (r_err_cnt != CNT_MAX) w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = S_EMPTY;
               w_match_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
      if (RST) begin
         r_state      <= S_EMPTY;
         r_prev       <= '0;
         r_match_cnt  <= '0;
         r_locked     <= 1'b0;
         r_err        <= 1'b0;
         r_err_sticky <= 1'b0;
         r_wrap       <= 1'b0;
         r_wrap_cnt   <= '0;
         r_err_cnt    <= '0;
         r_expected   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_prev       <= w_prev_nxt;
         r_match_cnt  <= w_match_nxt;
         r_locked     <= (w_state_nxt == S_LOCK);
         r_err        <= w_err_nxt;
         r_err_sticky <= w_err_sticky_nxt;
         r_wrap       <= w_wrap_nxt;
         r_wrap_cnt   <= w_wrap_cnt_nxt;
         r_err_cnt    <= w_err_cnt_nxt;
         r_expected   <= (w_state_nxt == S_EMPTY) ? '0 : w_prev_nxt + WIDTH'(1);
      end
   end

   assign bus.LOCKED     = r_locked;
   assign bus.ERR        = r_err;
   assign bus.ERR_STICKY = r_err_sticky;
   assign bus.WRAP       = r_wrap;
   assign bus.WRAP_CNT   = r_wrap_cnt;
   assign bus.ERR_CNT    = r_err_cnt;
   assign bus.EXPECTED   = r_expected;

endmodule

// File: tb/tb_count_seq_checker.sv
// Drives two checkers (CNT_W=8 and CNT_W=2) with one count stream and compares
// every output after each edge against a streak-based reference model.
module tb_count_seq_checker;

   localparam int LOCK_CYCLES = 2;

   logic CLK;
   logic RST;

   count_seq_checker_if #(.WIDTH(4), .CNT_W(8)) if0 ();
   count_seq_checker_if #(.WIDTH(4), .CNT_W(2)) if1 ();

   count_seq_checker #(.WIDTH(4), .LOCK_CYCLES(LOCK_CYCLES), .CNT_W(8)) u_dut0 (
      .CLK (CLK),
      .RST (RST),
      .bus (if0.slave)
   );

   count_seq_checker #(.WIDTH(4), .LOCK_CYCLES(LOCK_CYCLES), .CNT_W(2)) u_dut1 (
      .CLK (CLK),
      .RST (RST),
      .bus (if1.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: lock is simply "streak of correct increments >= LOCK_CYCLES".
   bit have_prev;
   int m_prev;
   int streak;
   bit m_locked;
   bit m_err;
   bit m_wrap;
   bit m_sticky;
   int m_err_cnt  [2];
   int m_wrap_cnt [2];
   int cnt_cap    [2] = '{255, 3};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_update(input bit rst, input bit en, input int q);
      bit was_locked;
      bit match;
      if (rst) begin
         have_prev = 0; m_prev = 0; streak = 0; m_locked = 0;
         m_err = 0; m_wrap = 0; m_sticky = 0;
         for (int k = 0; k < 2; k++) begin m_err_cnt[k] = 0; m_wrap_cnt[k] = 0; end
      end else if (!en) begin
         m_err = 0; m_wrap = 0;
      end else if (!have_prev) begin
         have_prev = 1; m_prev = q; streak = 0; m_err = 0; m_wrap = 0;
      end else begin
         was_locked = m_locked;
         match  = (q == (m_prev + 1) % 16);
         m_err  = was_locked && !match;
         m_wrap = was_locked && match && m_prev == 15 && q == 0;
         streak = match ? ((streak < 1000) ? streak + 1 : streak) : 0;
         if (m_err) m_sticky = 1;
         for (int k = 0; k < 2; k++) begin
            if (m_err  && m_err_cnt[k]  < cnt_cap[k]) m_err_cnt[k]++;
            if (m_wrap && m_wrap_cnt[k] < cnt_cap[k]) m_wrap_cnt[k]++;
         end
         m_locked = (streak >= LOCK_CYCLES);
         m_prev   = q;
      end
   endtask

   task automatic compare_all();
      int exp_val;
      exp_val = have_prev ? (m_prev + 1) % 16 : 0;
      check("locked0",   32'(if0.LOCKED),     32'(m_locked));
      check("err0",      32'(if0.ERR),        32'(m_err));
      check("sticky0",   32'(if0.ERR_STICKY), 32'(m_sticky));
      check("wrap0",     32'(if0.WRAP),       32'(m_wrap));
      check("wrapcnt0",  32'(if0.WRAP_CNT),   32'(m_wrap_cnt[0]));
      check("errcnt0",   32'(if0.ERR_CNT),    32'(m_err_cnt[0]));
      check("expected0", 32'(if0.EXPECTED),   32'(exp_val));
      check("errwrap0",  32'(if0.ERR & if0.WRAP), 32'd0);
      check("locked1",   32'(if1.LOCKED),     32'(m_locked));
      check("err1",      32'(if1.ERR),        32'(m_err));
      check("wrap1",     32'(if1.WRAP),       32'(m_wrap));
      check("wrapcnt1",  32'(if1.WRAP_CNT),   32'(m_wrap_cnt[1]));
      check("errcnt1",   32'(if1.ERR_CNT),    32'(m_err_cnt[1]));
   endtask

   task automatic step(input bit rst, input bit en, input int q);
      RST    = rst;
      if0.EN = en;  if0.Q = 4'(q);
      if1.EN = en;  if1.Q = 4'(q);
      model_update(rst, en, q);
      @(posedge CLK);
      @(negedge CLK);
      compare_all();
   endtask

   function automatic int nxt();
      return (m_prev + 1) % 16;
   endfunction

   initial begin
      int r;
      int wraps_seen;
      RST = 1'b1; if0.EN = 1'b0; if0.Q = '0; if1.EN = 1'b0; if1.Q = '0;
      @(negedge CLK);

      // Reset state.
      step(1, 0, 0);
      step(1, 1, 9);

      // Acquire from 0,1,2,3.
      step(0, 1, 0);
      step(0, 1, 1);
      check("t1_not_yet_locked", 32'(if0.LOCKED), 32'd0);
      step(0, 1, 2);
      check("t1_locked_after_2", 32'(if0.LOCKED), 32'd1);
      step(0, 1, 3);
      check("t1_expected_4", 32'(if0.EXPECTED), 32'd4);
      check("t1_sticky_0", 32'(if0.ERR_STICKY), 32'd0);

      // Locked wrap 14,15,0,1.
      while (m_prev != 13) step(0, 1, nxt());
      wraps_seen = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, nxt());
         if (if0.WRAP) wraps_seen++;
      end
      check("t2_wrap_pulses", 32'(wraps_seen), 32'd1);
      check("t2_wrap_cnt", 32'(if0.WRAP_CNT), 32'd1);

      // Mismatch at 5 -> 9, then relock on 10,11.
      while (m_prev != 5) step(0, 1, nxt());
      step(0, 1, 9);
      check("t3_err_pulse", 32'(if0.ERR), 32'd1);
      check("t3_unlocked", 32'(if0.LOCKED), 32'd0);
      step(0, 1, 10);
      step(0, 1, 11);
      check("t3_relocked", 32'(if0.LOCKED), 32'd1);
      check("t3_err_cnt", 32'(if0.ERR_CNT), 32'd1);
      check("t3_sticky", 32'(if0.ERR_STICKY), 32'd1);

      // EN=0 gap with a changing Q, then resume in sequence.
      for (int i = 0; i < 5; i++) step(0, 0, int'($urandom_range(0, 15)));
      step(0, 1, nxt());
      check("t4_locked", 32'(if0.LOCKED), 32'd1);
      check("t4_err_cnt", 32'(if0.ERR_CNT), 32'd1);

      // Five mismatches, each followed by relock; the CNT_W=2 copy saturates.
      for (int i = 0; i < 5; i++) begin
         step(0, 1, (m_prev + 5) % 16);
         step(0, 1, nxt());
         step(0, 1, nxt());
         step(0, 1, nxt());
      end
      check("t5_errcnt_sat", 32'(if1.ERR_CNT), 32'd3);
      check("t5_errcnt_wide", 32'(if0.ERR_CNT), 32'd6);

      // Repeated value while locked is a mismatch.
      step(0, 1, m_prev);
      check("rep_err", 32'(if0.ERR), 32'd1);

      // Reset mid-lock at 7, then relock from 8.
      step(0, 1, nxt());
      step(0, 1, nxt());
      while (m_prev != 6) step(0, 1, nxt());
      step(1, 1, 7);
      check("t6_reset_locked", 32'(if0.LOCKED), 32'd0);
      check("t6_reset_errcnt", 32'(if0.ERR_CNT), 32'd0);
      step(0, 1, 8);
      step(0, 1, 9);
      step(0, 1, 10);
      check("t6_relocked", 32'(if0.LOCKED), 32'd1);

      // Random stream: mostly correct increments, some repeats, jumps, EN gaps, rare resets.
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 80)      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), nxt());
         else if (r < 88) step(0, 1, m_prev);
         else             step(0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Downstream consumer of the free-running 4-bit up-counter output Q.
- Samples the count stream every enabled CLK edge and checks it advances by exactly +1 modulo 2^WIDTH.
- Reports lock, mismatch pulses, wrap-around events and saturating event counters for the bench and the status logic.

Parameters:
WIDTH, 4, width of the monitored count bus.
LOCK_CYCLES, 2, consecutive correct increments required to declare lock (legal range 1..15).
CNT_W, 8, width of the WRAP_CNT and ERR_CNT statistics counters.

Ports:
CLK  input  1  rising-edge clock, shared with the counter.
RST  input  1  synchronous reset, active-high.
EN  input  1  sample enable; Q is ignored on edges where EN=0.
Q  input  WIDTH  count value from the upstream counter.
LOCKED  output  1  high while in LOCK state.
ERR  output  1  one-cycle pulse on an increment mismatch while locked.
ERR_STICKY  output  1  set on the first ERR; cleared only by RST.
WRAP  output  1  one-cycle pulse on a locked max-to-0 transition.
WRAP_CNT  output  CNT_W  number of locked wraps, saturating at all-ones.
ERR_CNT  output  CNT_W  number of ERR pulses, saturating at all-ones.
EXPECTED  output  WIDTH  next expected value, prev+1 mod 2^WIDTH; 0 when in EMPTY.

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high. All outputs are registered.
- Reset: on a CLK edge with RST=1, RST overrides EN and all other inputs, including mid-lock. That edge sets:
  - state=EMPTY, prev=0, match_cnt=0;
  - LOCKED=0, ERR=0, ERR_STICKY=0, WRAP=0, WRAP_CNT=0, ERR_CNT=0, EXPECTED=0.
- Sampling: only edges with EN=1 and RST=0 are evaluated. On EN=0 edges, state, prev, match_cnt and the counters hold, and the ERR and WRAP pulses are driven 0.
- Expected value: exp = (prev+1) mod 2^WIDTH, a WIDTH-bit add with the carry discarded.
- State EMPTY: the first sample loads prev=Q, sets match_cnt=0 and moves to ACQ. No ERR.
- State ACQ:
  - Q==exp: match_cnt++. If match_cnt reaches LOCK_CYCLES, move to LOCK and LOCKED=1 from the next cycle.
  - Q!=exp: match_cnt=0, stay in ACQ. No ERR and no ERR_CNT change.
  - prev=Q on every sample.
- State LOCK:
  - Q==exp: stay in LOCK. If prev=2^WIDTH-1 and Q=0, WRAP=1 for one cycle and WRAP_CNT++ (saturating).
  - Q!=exp: ERR=1 for one cycle, ERR_CNT++ (saturating), ERR_STICKY=1, LOCKED=0, state=ACQ, match_cnt=0.
  - prev=Q on every sample.
- Latency: ERR, WRAP, LOCKED and the counters reflect a sample in the cycle immediately after the edge at which it was taken.
- Boundaries:
  - A repeated value (Q==prev) while locked is a mismatch.
  - A wrap seen during ACQ counts as a normal match. It does not pulse WRAP or increment WRAP_CNT.
  - A wrap that completes lock (transition ACQ to LOCK on the same edge) does not pulse WRAP.
  - WRAP_CNT and ERR_CNT hold at 2^CNT_W-1 and never roll over.
  - ERR and WRAP are never high in the same cycle.
  - A mismatch sample becomes the new prev, so re-acquisition starts from it immediately.

Test Plan:
1. Reset, then EN=1 with Q=0,1,2,3 -> LOCKED=1 in the cycle after the Q=2 sample; EXPECTED=4 after the Q=3 sample; ERR_STICKY=0.
2. Locked, then run Q=14,15,0,1 -> WRAP pulses once (cycle after the Q=0 sample); WRAP_CNT=1; ERR=0.
3. Locked at Q=5, then inject Q=9, 10, 11 -> ERR pulses once after 9; ERR_CNT=1; LOCKED drops, then returns 1 after the 11 sample; ERR_STICKY stays 1.
4. Locked, then hold EN=0 for 5 cycles while Q keeps changing, and resume EN=1 with Q=prev+1 -> no ERR; LOCKED stays 1; counters unchanged.
5. CNT_W=2, locked; force 5 mismatches, each followed by re-lock -> ERR_CNT saturates at 3; ERR pulses 5 times.
6. Assert RST for one cycle mid-lock at Q=7 -> all outputs 0 the next cycle; Q=8,9,10 then relocks (LOCKED=1 after the 10 sample).
